fifo_push_arbiter: RTL and testbench

//  Round-robin arbiter sharing one fifo write port among NUM_REQ producers.

---
 rtl/fifo_push_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
// Round-robin arbiter that lets NUM_REQ producers share one fifo write port.
// The winning word is captured in a single output register, which drives the
// fifo push/data pins and waits while the fifo reports full. A flush request
// discards any word still held in that register and then pulses the fifo
// flush for one cycle, so no stale word can reach the fifo afterwards.

module fifo_push_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int XLEN    = 32,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   input  logic [NUM_REQ*XLEN-1:0] req_data_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic                    flush_req_i,
   input  logic                    fifo_full_i,
   output logic                    fifo_push_o,
   output logic [XLEN-1:0]         fifo_data_o,
   output logic                    fifo_flush_o,
   output logic [ID_W-1:0]         last_id_o,
   output logic                    busy_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] outData_q, outData_d;
   logic [ID_W-1:0] outId_q, outId_d;
   logic [ID_W-1:0] ptr_q, ptr_d;

   logic [ID_W-1:0] winner;
   logic [ID_W:0]   idx;
   logic [XLEN-1:0] selData;
   logic            anyValid;
   logic            accept;
   logic            outVld;
   logic            inFlush;
   logic            drain;
   logic            canLoad;

   // The output register holds a word exactly when the FSM is in LOADED
   assign outVld  = (state_q == LOADED);
   assign inFlush = (state_q == FLUSH);
   assign drain   = fifo_push_o;
   assign canLoad = (~outVld | drain) & ~flush_req_i & ~inFlush;
   assign accept  = canLoad & anyValid;

   assign fifo_data_o = outData_q;
   assign last_id_o   = outId_q;

   // Round-robin search starting at the pointer, wrapping modulo NUM_REQ so
   // that non power-of-two requester counts never index past the last one
   always_comb begin
      winner   = '0;
      anyValid = 1'b0;
      idx      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (idx >= (ID_W+1)'(NUM_REQ)) begin
            idx = idx - (ID_W+1)'(NUM_REQ);
         end
         if (!anyValid && req_valid_i[idx[ID_W-1:0]]) begin
            anyValid = 1'b1;
            winner   = idx[ID_W-1:0];
         end
      end
   end

   // Grant is a pure function of valids, pointer and load capacity, never of data
   always_comb begin
      req_ready_o = '0;
      if (accept) begin
         req_ready_o = NUM_REQ'(1) << winner;
      end
   end

   // Word mux for the winning requester
   always_comb begin
      selData = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (winner == ID_W'(k)) begin
            selData = req_data_i[k*XLEN +: XLEN];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; flush always beats a pending accept or drain
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (flush_req_i) begin
               state_d = FLUSH;
            end else if (accept) begin
               state_d = LOADED;
            end
         end
         LOADED: begin
            if (flush_req_i) begin
               state_d = FLUSH;
            end else if (accept) begin
               state_d = LOADED;
            end else if (drain) begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            state_d = flush_req_i ? FLUSH : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs; push is blocked while flushing so a dropped word never leaks
   always_comb begin
      fifo_push_o  = outVld & ~fifo_full_i & ~inFlush;
      fifo_flush_o = inFlush;
      busy_o       = outVld | inFlush;
   end

   // Next value of the output word, its owner and the round-robin pointer
   always_comb begin
      outData_d = outData_q;
      outId_d   = outId_q;
      ptr_d     = ptr_q;
      if (accept) begin
         outData_d = selData;
         outId_d   = winner;
         ptr_d     = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end
   end

   // Datapath registers for the held word and the arbitration pointer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outData_q <= '0;
         outId_q   <= '0;
         ptr_q     <= '0;
      end else begin
         outData_q <= outData_d;
         outId_q   <= outId_d;
         ptr_q     <= ptr_d;
      end
   end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Testbench for fifo_push_arbiter: directed scenarios followed by a randomised
// run against a behavioural model with a four-entry fifo.

module tb_fifo_push_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int XLEN      = 32;
   localparam int ID_W      = 2;
   localparam int FIFO_SIZE = 4;

   logic                    clk_i;
   logic                    rst_i;
   logic [NUM_REQ-1:0]      req_valid_i;
   logic [NUM_REQ*XLEN-1:0] req_data_i;
   logic [NUM_REQ-1:0]      req_ready_o;
   logic                    flush_req_i;
   logic                    fifo_full_i;
   logic                    fifo_push_o;
   logic [XLEN-1:0]         fifo_data_o;
   logic                    fifo_flush_o;
   logic [ID_W-1:0]         last_id_o;
   logic                    busy_o;

   int testsRun    = 0;
   int testsFailed = 0;

   fifo_push_arbiter #(
      .NUM_REQ(NUM_REQ),
      .XLEN   (XLEN)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .flush_req_i (flush_req_i),
      .fifo_full_i (fifo_full_i),
      .fifo_push_o (fifo_push_o),
      .fifo_data_o (fifo_data_o),
      .fifo_flush_o(fifo_flush_o),
      .last_id_o   (last_id_o),
      .busy_o      (busy_o)
   );

   // 10 ns clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Advance to just after the next rising edge, where inputs are driven
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic setData(input int k, input logic [XLEN-1:0] w);
      req_data_i[k*XLEN +: XLEN] = w;
   endtask

   task automatic test_reset();
      rst_i       = 1'b1;
      req_valid_i = '0;
      req_data_i  = '0;
      flush_req_i = 1'b0;
      fifo_full_i = 1'b0;
      #2;
      testsRun++;
      if ({req_ready_o, fifo_push_o, fifo_data_o, fifo_flush_o, last_id_o, busy_o} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: got ready=%b push=%b data=%h flush=%b id=%0d busy=%b want all 0",
                  req_ready_o, fifo_push_o, fifo_data_o, fifo_flush_o, last_id_o, busy_o);
      end
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      testsRun++;
      if (busy_o !== 1'b0 || fifo_push_o !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_release: got busy=%b push=%b want 0 0", busy_o, fifo_push_o);
      end
   endtask

   task automatic test_single_req();
      tick();
      setData(0, 32'h0000_0000);
      setData(1, 32'h1111_0001);
      setData(2, 32'hDEAD_BEEF);
      setData(3, 32'h3333_0003);
      req_valid_i = 4'b0100;
      #1;
      testsRun++;
      if (req_ready_o !== 4'b0100 || fifo_push_o !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL single_grant: got ready=%b push=%b want 0100 0", req_ready_o, fifo_push_o);
      end
      tick();
      req_valid_i = '0;
      #1;
      testsRun++;
      if (fifo_push_o !== 1'b1 || fifo_data_o !== 32'hDEAD_BEEF || last_id_o !== 2'd2 || busy_o !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL single_push: got push=%b data=%h id=%0d busy=%b want 1 deadbeef 2 1",
                  fifo_push_o, fifo_data_o, last_id_o, busy_o);
      end
      tick();
      #1;
      testsRun++;
      if (fifo_push_o !== 1'b0 || busy_o !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL single_drained: got push=%b busy=%b want 0 0", fifo_push_o, busy_o);
      end
   endtask

   task automatic test_reset_mid();
      // Pointer sits at 3, so a lone request from 1 exercises the wrap
      setData(1, 32'h1234_5678);
      req_valid_i = 4'b0010;
      #1;
      testsRun++;
      if (req_ready_o !== 4'b0010) begin
         testsFailed++;
         $display("[TB] FAIL wrap_grant: got ready=%b want 0010", req_ready_o);
      end
      tick();
      req_valid_i = '0;
      #2;
      rst_i = 1'b1;
      #1;
      testsRun++;
      if ({req_ready_o, fifo_push_o, fifo_data_o, fifo_flush_o, last_id_o, busy_o} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_mid: got ready=%b push=%b data=%h flush=%b id=%0d busy=%b want all 0",
                  req_ready_o, fifo_push_o, fifo_data_o, fifo_flush_o, last_id_o, busy_o);
      end
      tick();
      rst_i = 1'b0;
      #1;
      testsRun++;
      if (busy_o !== 1'b0 || fifo_push_o !== 1'b0 || fifo_flush_o !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_mid_release: got busy=%b push=%b flush=%b want 0 0 0",
                  busy_o, fifo_push_o, fifo_flush_o);
      end
   endtask

   task automatic test_fairness();
      int pushCount;
      pushCount = 0;
      for (int k = 0; k < NUM_REQ; k++) setData(k, 32'hA000_0000 + k);
      req_valid_i = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (fifo_push_o === 1'b1) pushCount++;
         testsRun++;
         if (req_ready_o !== (4'b0001 << (c % 4))) begin
            testsFailed++;
            $display("[TB] FAIL fair_grant[%0d]: got ready=%b want %b", c, req_ready_o, 4'b0001 << (c % 4));
         end
         if (c > 0) begin
            testsRun++;
            if (fifo_push_o !== 1'b1 || fifo_data_o !== 32'hA000_0000 + (c - 1) % 4 ||
                last_id_o !== ID_W'((c - 1) % 4)) begin
               testsFailed++;
               $display("[TB] FAIL fair_push[%0d]: got push=%b data=%h id=%0d want 1 %h %0d",
                        c, fifo_push_o, fifo_data_o, last_id_o, 32'hA000_0000 + (c - 1) % 4, (c - 1) % 4);
            end
         end
         tick();
      end
      req_valid_i = '0;
      #1;
      if (fifo_push_o === 1'b1) pushCount++;
      testsRun++;
      if (fifo_data_o !== 32'hA000_0003 || last_id_o !== 2'd3) begin
         testsFailed++;
         $display("[TB] FAIL fair_last: got data=%h id=%0d want a0000003 3", fifo_data_o, last_id_o);
      end
      testsRun++;
      if (pushCount !== 8) begin
         testsFailed++;
         $display("[TB] FAIL fair_push_count: got %0d want 8", pushCount);
      end
      tick();
      #1;
      testsRun++;
      if (fifo_push_o !== 1'b0 || busy_o !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL fair_drained: got push=%b busy=%b want 0 0", fifo_push_o, busy_o);
      end
   endtask

   task automatic test_backpressure();
      tick();
      setData(1, 32'h1111_1111);
      setData(0, 32'h0000_0F0F);
      req_valid_i = 4'b0010;
      #1;
      testsRun++;
      if (req_ready_o !== 4'b0010) begin
         testsFailed++;
         $display("[TB] FAIL bp_grant: got ready=%b want 0010", req_ready_o);
      end
      tick();
      req_valid_i = 4'b0001;
      fifo_full_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         testsRun++;
         if (fifo_push_o !== 1'b0 || req_ready_o !== 4'b0000 || fifo_data_o !== 32'h1111_1111 || busy_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold[%0d]: got push=%b ready=%b data=%h busy=%b want 0 0000 11111111 1",
                     c, fifo_push_o, req_ready_o, fifo_data_o, busy_o);
         end
         tick();
      end
      fifo_full_i = 1'b0;
      req_valid_i = '0;
      #1;
      testsRun++;
      if (fifo_push_o !== 1'b1 || fifo_data_o !== 32'h1111_1111 || last_id_o !== 2'd1) begin
         testsFailed++;
         $display("[TB] FAIL bp_release: got push=%b data=%h id=%0d want 1 11111111 1",
                  fifo_push_o, fifo_data_o, last_id_o);
      end
      tick();
      #1;
      testsRun++;
      if (fifo_push_o !== 1'b0 || busy_o !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL bp_no_duplicate: got push=%b busy=%b want 0 0", fifo_push_o, busy_o);
      end
   endtask

   task automatic test_flush();
      tick();
      setData(3, 32'hCAFE_BABE);
      req_valid_i = 4'b1000;
      #1;
      testsRun++;
      if (req_ready_o !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL flush_grant: got ready=%b want 1000", req_ready_o);
      end
      tick();
      req_valid_i = '0;
      fifo_full_i = 1'b1;
      flush_req_i = 1'b1;
      #1;
      testsRun++;
      if (fifo_push_o !== 1'b0 || fifo_data_o !== 32'hCAFE_BABE || busy_o !== 1'b1 || fifo_flush_o !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL flush_loaded: got push=%b data=%h busy=%b flush=%b want 0 cafebabe 1 0",
                  fifo_push_o, fifo_data_o, busy_o, fifo_flush_o);
      end
      tick();
      flush_req_i = 1'b0;
      fifo_full_i = 1'b0;
      setData(0, 32'h0BAD_F00D);
      req_valid_i = 4'b0001;
      #1;
      testsRun++;
      if (fifo_flush_o !== 1'b1 || fifo_push_o !== 1'b0 || req_ready_o !== 4'b0000 || busy_o !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL flush_active: got flush=%b push=%b ready=%b busy=%b want 1 0 0000 1",
                  fifo_flush_o, fifo_push_o, req_ready_o, busy_o);
      end
      tick();
      #1;
      testsRun++;
      if (fifo_flush_o !== 1'b0 || fifo_push_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 4'b0001) begin
         testsFailed++;
         $display("[TB] FAIL flush_after: got flush=%b push=%b busy=%b ready=%b want 0 0 0 0001",
                  fifo_flush_o, fifo_push_o, busy_o, req_ready_o);
      end
      tick();
      req_valid_i = '0;
      #1;
      testsRun++;
      if (fifo_push_o !== 1'b1 || fifo_data_o !== 32'h0BAD_F00D || last_id_o !== 2'd0) begin
         testsFailed++;
         $display("[TB] FAIL flush_next_word: got push=%b data=%h id=%0d want 1 0badf00d 0",
                  fifo_push_o, fifo_data_o, last_id_o);
      end
      tick();
   endtask

   // First valid requester searching from p upward, -1 if none
   function automatic int rrWinner(input logic [NUM_REQ-1:0] v, input int p);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic test_scoreboard();
      int seq[NUM_REQ];
      int nextPushSeq[NUM_REQ];
      int fifoCount;
      int mPtr;
      int mId;
      int win;
      logic mVld;
      logic mFlush;
      logic [XLEN-1:0] mData;
      logic expPush;
      logic canLoad;
      logic [NUM_REQ-1:0] expReady;
      logic draining;
      logic pop;

      for (int k = 0; k < NUM_REQ; k++) begin
         seq[k]         = 0;
         nextPushSeq[k] = 0;
      end
      fifoCount = 0;
      mPtr      = 0;
      mId       = 0;
      mVld      = 1'b0;
      mFlush    = 1'b0;
      mData     = '0;

      rst_i       = 1'b1;
      req_valid_i = '0;
      flush_req_i = 1'b0;
      fifo_full_i = 1'b0;
      tick();
      rst_i = 1'b0;

      for (int cyc = 0; cyc < 2000; cyc++) begin
         draining = (cyc >= 1990);
         for (int k = 0; k < NUM_REQ; k++) begin
            req_valid_i[k] = !draining && ($urandom_range(0, 99) < 60);
            req_data_i[k*XLEN +: XLEN] = {4'(k), 28'(seq[k])};
         end
         flush_req_i = !draining && ($urandom_range(0, 19) == 0);
         fifo_full_i = (fifoCount == FIFO_SIZE);
         #1;

         expPush  = mVld & ~fifo_full_i & ~mFlush;
         canLoad  = (~mVld | expPush) & ~flush_req_i & ~mFlush;
         win      = rrWinner(req_valid_i, mPtr);
         expReady = '0;
         if (canLoad && win >= 0) expReady[win] = 1'b1;

         testsRun++;
         if (req_ready_o !== expReady || fifo_push_o !== expPush || fifo_flush_o !== mFlush ||
             busy_o !== (mVld | mFlush)) begin
            testsFailed++;
            $display("[TB] FAIL sb_ctrl[%0d]: got ready=%b push=%b flush=%b busy=%b want %b %b %b %b",
                     cyc, req_ready_o, fifo_push_o, fifo_flush_o, busy_o,
                     expReady, expPush, mFlush, mVld | mFlush);
         end
         if (expPush) begin
            testsRun++;
            if (fifo_data_o !== {4'(mId), 28'(nextPushSeq[mId])} || last_id_o !== ID_W'(mId)) begin
               testsFailed++;
               $display("[TB] FAIL sb_order[%0d]: got data=%h id=%0d want %h %0d",
                        cyc, fifo_data_o, last_id_o, {4'(mId), 28'(nextPushSeq[mId])}, mId);
            end
            nextPushSeq[mId]++;
         end

         pop = (fifoCount > 0) && (draining || ($urandom_range(0, 1) == 1));
         if (mFlush) begin
            fifoCount = 0;
         end else begin
            fifoCount = fifoCount + (expPush ? 1 : 0) - (pop ? 1 : 0);
         end

         if (mFlush) begin
            mFlush = flush_req_i;
            mVld   = 1'b0;
         end else if (flush_req_i) begin
            if (mVld && !expPush) nextPushSeq[mId]++;
            mFlush = 1'b1;
            mVld   = 1'b0;
         end else if (expReady != '0) begin
            mVld  = 1'b1;
            mData = req_data_i[win*XLEN +: XLEN];
            mId   = win;
            mPtr  = (win + 1) % NUM_REQ;
            seq[win]++;
         end else if (expPush) begin
            mVld = 1'b0;
         end
         tick();
      end

      for (int k = 0; k < NUM_REQ; k++) begin
         testsRun++;
         if (nextPushSeq[k] !== seq[k]) begin
            testsFailed++;
            $display("[TB] FAIL sb_no_loss[%0d]: got pushed_or_flushed=%0d want accepted=%0d",
                     k, nextPushSeq[k], seq[k]);
         end
      end
      testsRun++;
      if (busy_o !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL sb_idle_end: got busy=%b want 0", busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_req();
      test_reset_mid();
      test_fairness();
      test_backpressure();
      test_flush();
      test_scoreboard();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
